// File: rtl/seq_shifter_if.sv
// seq_shifter_if: request/response bundle for the iterative shift unit.
//   Request  : in_valid, in_ready, in_data, in_dir (0 = left, 1 = right), in_amt
//   Response : out_valid, out_ready, out_data
//   Optional : in_rot (rotate select), present only when SEQ_SHIFTER_ROTATE_EN is defined.
// Modports: master = requester / result consumer, slave = the shift unit.
interface seq_shifter_if #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
);
   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in_data;
   logic             in_dir;
   logic [AMT_W-1:0] in_amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
   logic             in_rot;
`endif
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] out_data;

`ifdef SEQ_SHIFTER_ROTATE_EN
   modport master (output in_valid, in_data, in_dir, in_amt, in_rot, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_dir, in_amt, in_rot, out_ready,
                   output in_ready, out_valid, out_data);
`else
   modport master (output in_valid, in_data, in_dir, in_amt, out_ready,
                   input  in_ready, out_valid, out_data);
   modport slave  (input  in_valid, in_data, in_dir, in_amt, out_ready,
                   output in_ready, out_valid, out_data);
`endif
endinterface

// File: rtl/seq_shifter.sv
// seq_shifter: multi-cycle shift unit, one bit position per clock.
// Accepts operand/direction/amount on the request side of bus, returns the
// shifted result on the response side. Logical zero-fill shift by default;
// defining SEQ_SHIFTER_ROTATE_EN adds bus.in_rot to select rotate instead.
// Ports:
//   clk  : clock, rising edge
//   rst  : synchronous active-high reset
//   bus  : seq_shifter_if.slave (request and response handshakes)
//   busy : high while in SHIFT or DONE
//
// state  | meaning
// -------+-------------------------------------------------------------
// S_IDLE | ready for a request (in_ready = 1)
// S_SHIFT| shifting one position per clock, counter counts down to 1
// S_DONE | result presented (out_valid = 1), waiting for out_ready
module seq_shifter #(
   parameter int WIDTH = 32,
   parameter int AMT_W = 5
) (
   input  logic              clk,
   input  logic              rst,
   seq_shifter_if.slave      bus,
   output logic              busy
);

   typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_DONE} state_t;

   state_t           state_q;
   logic [WIDTH-1:0] data_q;
   logic [WIDTH-1:0] data_d;
   logic [WIDTH-1:0] out_data_q;
   logic [AMT_W-1:0] cnt_q;
   logic             dir_q;
   logic             in_ready_q;
   logic             out_valid_q;
   logic             busy_q;
   logic             fill_left;
   logic             fill_right;
`ifdef SEQ_SHIFTER_ROTATE_EN
   logic             rot_q;
`endif

   // One-position step in the latched direction; fill bit is zero unless rotating.
   always_comb begin
      fill_left  = 1'b0;
      fill_right = 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      if (rot_q) begin
         fill_left  = data_q[WIDTH-1];
         fill_right = data_q[0];
      end
`endif
      data_d = dir_q ? {fill_right, data_q[WIDTH-1:1]}
                     : {data_q[WIDTH-2:0], fill_left};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q     <= S_IDLE;
         data_q      <= '0;
         out_data_q  <= '0;
         cnt_q       <= '0;
         dir_q       <= 1'b0;
         in_ready_q  <= 1'b1;
         out_valid_q <= 1'b0;
         busy_q      <= 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
         rot_q       <= 1'b0;
`endif
      end else begin
         case (state_q)
            S_IDLE: begin
               if (bus.in_valid && in_ready_q) begin
                  data_q     <= bus.in_data;
                  dir_q      <= bus.in_dir;
                  cnt_q      <= bus.in_amt;
`ifdef SEQ_SHIFTER_ROTATE_EN
                  rot_q      <= bus.in_rot;
`endif
                  in_ready_q <= 1'b0;
                  busy_q     <= 1'b1;
                  if (bus.in_amt == '0) begin
                     state_q     <= S_DONE;
                     out_valid_q <= 1'b1;
                     out_data_q  <= bus.in_data;
                  end else begin
                     state_q <= S_SHIFT;
                  end
               end
            end
            S_SHIFT: begin
               data_q <= data_d;
               cnt_q  <= cnt_q - AMT_W'(1);
               if (cnt_q == AMT_W'(1)) begin
                  state_q     <= S_DONE;
                  out_valid_q <= 1'b1;
                  // Separate result register so out_data survives the next acceptance.
                  out_data_q  <= data_d;
               end
            end
            S_DONE: begin
               if (bus.out_ready) begin
                  state_q     <= S_IDLE;
                  out_valid_q <= 1'b0;
                  busy_q      <= 1'b0;
                  in_ready_q  <= 1'b1;
               end
            end
            default: begin
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign bus.in_ready  = in_ready_q;
   assign bus.out_valid = out_valid_q;
   assign bus.out_data  = out_data_q;
   assign busy          = busy_q;

endmodule

// File: tb/tb_seq_shifter.sv
module tb_seq_shifter;
   localparam int W  = 32;
   localparam int AW = 5;

   logic clk = 1'b0;
   logic rst = 1'b1;
   logic busy;

   seq_shifter_if #(.WIDTH(W), .AMT_W(AW)) ifs ();

   seq_shifter #(.WIDTH(W), .AMT_W(AW)) dut (
      .clk  (clk),
      .rst  (rst),
      .bus  (ifs.slave),
      .busy (busy)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int n_cmp = 0;
   int n_err = 0;
   int acc_cyc = 0;
   logic [W-1:0] sb_q[$];

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_cmp++;
      assert (obs === exp) else begin
         n_err++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   function automatic logic [W-1:0] model(input logic [W-1:0] d, input logic dr,
                                          input int a, input logic r);
      if (!dr) return r ? ((d << a) | (d >> (W - a))) : (d << a);
      else     return r ? ((d >> a) | (d << (W - a))) : (d >> a);
   endfunction

   task automatic drive_req(input logic [W-1:0] d, input logic dr, input int a, input logic r);
      ifs.in_valid = 1'b1;
      ifs.in_data  = d;
      ifs.in_dir   = dr;
      ifs.in_amt   = AW'(a);
`ifdef SEQ_SHIFTER_ROTATE_EN
      ifs.in_rot   = r;
`endif
   endtask

   // Called at a negedge; holds the request until accepted, returns at the negedge after acceptance.
   task automatic send(input logic [W-1:0] d, input logic dr, input int a, input logic r,
                       input bit push);
      bit ok;
      ok = 1'b0;
      if (push) sb_q.push_back(model(d, dr, a, r));
      drive_req(d, dr, a, r);
      for (int i = 0; i < 200; i++) begin
         if (ifs.in_ready) begin
            @(negedge clk);
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      acc_cyc      = cyc;
      ifs.in_valid = 1'b0;
      chk("accept_seen", 64'(ok), 64'd1);
   endtask

   // Waits for a result, checks latency (if exp_lat >= 0) and data, completes the handshake.
   task automatic recv(input int exp_lat, input string tag);
      bit ok;
      logic [W-1:0] exp_d;
      ok = 1'b0;
      ifs.out_ready = 1'b1;
      for (int i = 0; i < 200; i++) begin
         if (ifs.out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk({tag, "_valid"}, 64'(ok), 64'd1);
      if (ok) begin
         if (exp_lat >= 0) chk({tag, "_lat"}, 64'(cyc - acc_cyc), 64'(exp_lat));
         chk({tag, "_busy"}, 64'(busy), 64'd1);
         chk({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
         if (sb_q.size() > 0) begin
            exp_d = sb_q.pop_front();
            chk({tag, "_data"}, 64'(ifs.out_data), 64'(exp_d));
         end
         @(negedge clk);
         chk({tag, "_valid_drop"}, 64'(ifs.out_valid), 64'd0);
         chk({tag, "_ready_back"}, 64'(ifs.in_ready), 64'd1);
      end
   endtask

   initial begin
      #500000;
      $display("FAIL watchdog timeout");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      bit ok;
      ifs.in_valid  = 1'b0;
      ifs.in_data   = '0;
      ifs.in_dir    = 1'b0;
      ifs.in_amt    = '0;
      ifs.out_ready = 1'b0;
`ifdef SEQ_SHIFTER_ROTATE_EN
      ifs.in_rot    = 1'b0;
`endif
      rst = 1'b1;
      repeat (2) @(negedge clk);
      chk("rst_in_ready", 64'(ifs.in_ready), 64'd1);
      chk("rst_out_valid", 64'(ifs.out_valid), 64'd0);
      chk("rst_busy", 64'(busy), 64'd0);
      chk("rst_out_data", 64'(ifs.out_data), 64'd0);
      rst = 1'b0;
      @(negedge clk);

      // Reset in the middle of a shift: nothing may come out.
      send(32'h0000_00FF, 1'b0, 20, 1'b0, 1'b0);
      repeat (5) @(negedge clk);
      chk("mid_busy", 64'(busy), 64'd1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      chk("mid_rst_in_ready", 64'(ifs.in_ready), 64'd1);
      chk("mid_rst_out_valid", 64'(ifs.out_valid), 64'd0);
      chk("mid_rst_busy", 64'(busy), 64'd0);
      chk("mid_rst_out_data", 64'(ifs.out_data), 64'd0);
      ifs.out_ready = 1'b1;
      cnt = 0;
      for (int i = 0; i < 30; i++) begin
         @(negedge clk);
         if (ifs.out_valid) cnt++;
      end
      chk("mid_no_result", 64'(cnt), 64'd0);

      // Full-range left shift.
      send(32'h0000_0001, 1'b0, 31, 1'b0, 1'b1);
      recv(31, "left31");

      // Zero amount.
      send(32'hDEAD_BEEF, 1'b1, 0, 1'b0, 1'b1);
      recv(0, "right0");

      // Back-pressure with a second request held meanwhile.
      ifs.out_ready = 1'b0;
      send(32'hF000_0000, 1'b1, 4, 1'b0, 1'b1);
      sb_q.push_back(model(32'h0000_0003, 1'b0, 2, 1'b0));
      drive_req(32'h0000_0003, 1'b0, 2, 1'b0);
      ok = 1'b0;
      for (int i = 0; i < 50; i++) begin
         if (ifs.out_valid) begin
            ok = 1'b1;
            break;
         end
         @(negedge clk);
      end
      chk("bp_valid", 64'(ok), 64'd1);
      for (int i = 0; i < 10; i++) begin
         chk("bp_data_hold", 64'(ifs.out_data), 64'(sb_q[0]));
         chk("bp_valid_hold", 64'(ifs.out_valid), 64'd1);
         chk("bp_no_accept", 64'(ifs.in_ready), 64'd0);
         @(negedge clk);
      end
      recv(-1, "bp");
      @(negedge clk);
      acc_cyc = cyc;
      ifs.in_valid = 1'b0;
      chk("bp_held_accept", 64'(ifs.in_ready), 64'd0);
      recv(2, "bp_held");

      // Back-to-back requests, second held during the first.
      send(32'h0000_0001, 1'b0, 3, 1'b0, 1'b1);
      sb_q.push_back(model(32'h0000_0080, 1'b1, 7, 1'b0));
      drive_req(32'h0000_0080, 1'b1, 7, 1'b0);
      recv(3, "b2b1");
      @(negedge clk);
      acc_cyc = cyc;
      ifs.in_valid = 1'b0;
      chk("b2b_accept_ready", 64'(ifs.in_ready), 64'd0);
      chk("b2b_accept_busy", 64'(busy), 64'd1);
      recv(7, "b2b2");

      // All-ones boundaries.
      send(32'hFFFF_FFFF, 1'b0, 31, 1'b0, 1'b1);
      recv(31, "ones_left31");
      send(32'hFFFF_FFFF, 1'b1, 31, 1'b0, 1'b1);
      recv(31, "ones_right31");
      send(32'hA5A5_5A5A, 1'b1, 13, 1'b0, 1'b1);
      recv(13, "mixed_right13");

`ifdef SEQ_SHIFTER_ROTATE_EN
      send(32'h8000_0001, 1'b0, 1, 1'b1, 1'b1);
      recv(1, "rotl1");
      send(32'h8000_0001, 1'b0, 1, 1'b0, 1'b1);
      recv(1, "shl1_norot");
      send(32'h8000_0001, 1'b1, 1, 1'b1, 1'b1);
      recv(1, "rotr1");
      send(32'h1234_5678, 1'b0, 8, 1'b1, 1'b1);
      recv(8, "rotl8");
`endif

      chk("sb_drained", 64'(sb_q.size()), 64'd0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
      $finish;
   end
endmodule
